// File: rtl/gtp_pll0_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : gtp_pll0_lock_monitor
// Description : Lock qualification and supervision for the GTP common PLL0.
//               Enables PLL0 lock detection while supervising. It debounces
//               lock into a single ready qualifier, counts loss-of-lock events
//               and flags lock-acquisition timeouts.
//
// Ports
//   PLL0LOCKDETCLK      in   lock-detect clock (all logic on this domain)
//   pll0_reset_int      in   asynchronous active-high reset (shared with PLL0)
//   i_start             in   level: 1 = supervise PLL0, 0 = return to IDLE
//   i_clr_status        in   one-cycle pulse, clears o_lol_count/o_lol_sticky
//   i_pll0_lock         in   PLL0LOCK
//   i_pll0_fbclklost    in   PLL0FBCLKLOST
//   i_pll0_refclklost   in   PLL0REFCLKLOST
//   o_pll0_lock_en      out  to PLL0LOCKEN
//   o_pll_ready         out  qualified lock
//   o_state[2:0]        out  IDLE=0 WAIT_LOCK=1 QUALIFY=2 READY=3 LOST=4 TIMEOUT=5
//   o_lol_count[7:0]    out  loss-of-lock events, saturating at 255
//   o_lol_sticky        out  set on any loss of lock
//   o_timeout_flag      out  high while in TIMEOUT
//
// Parameters
//   STABLE_CYCLES       consecutive lock-good cycles before ready (1..65535)
//   TIMEOUT_CYCLES      cycles allowed in WAIT_LOCK/LOST (2..65535)
//
// Revision    : 1.0 - initial release
// ============================================================================
module gtp_pll0_lock_monitor #(
    parameter int STABLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       PLL0LOCKDETCLK,
    input  logic       pll0_reset_int,
    input  logic       i_start,
    input  logic       i_clr_status,
    input  logic       i_pll0_lock,
    input  logic       i_pll0_fbclklost,
    input  logic       i_pll0_refclklost,
    output logic       o_pll0_lock_en,
    output logic       o_pll_ready,
    output logic [2:0] o_state,
    output logic [7:0] o_lol_count,
    output logic       o_lol_sticky,
    output logic       o_timeout_flag
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [15:0] c_STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] c_TIMER_MAX    = 16'hFFFF;
    localparam logic [7:0]  c_LOL_MAX      = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_QUALIFY   = 3'd2,
        S_READY     = 3'd3,
        S_LOST      = 3'd4,
        S_TIMEOUT   = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [15:0] r_timer;
    logic [15:0] r_stable_cnt;
    logic [7:0]  r_lol_count;
    logic        r_lol_sticky;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_lock_good;
    logic [15:0] w_timer_inc;
    logic        w_timer_expired;
    logic        w_loss_event;
    logic [7:0]  w_lol_base;
    logic [7:0]  w_lol_next;

    assign w_lock_good = i_pll0_lock & ~i_pll0_fbclklost & ~i_pll0_refclklost;

    // The timer keeps running through QUALIFY so that repeated glitches cannot
    // extend the acquire window indefinitely. It saturates rather than wraps,
    // and expiry is a >= compare: if QUALIFY carried the timer past the limit,
    // the very next WAIT_LOCK cycle still times out instead of waiting for a
    // 16-bit wrap.
    assign w_timer_inc     = (r_timer == c_TIMER_MAX) ? r_timer : (r_timer + 16'd1);
    assign w_timer_expired = (r_timer >= c_TIMEOUT_LAST);

    // A loss only counts while supervising; start=0 wins and moves to IDLE.
    assign w_loss_event = i_start & (r_state == S_READY) & ~w_lock_good;

    // Clear is applied first and the loss increment on top, so a coincident
    // clear and loss leaves exactly one recorded event.
    assign w_lol_base = i_clr_status ? 8'd0 : r_lol_count;
    assign w_lol_next = w_loss_event
                      ? ((w_lol_base == c_LOL_MAX) ? w_lol_base : (w_lol_base + 8'd1))
                      : w_lol_base;

    // ------------------------------------------------------------------------
    // Supervision state machine and status counters
    // ------------------------------------------------------------------------
    always_ff @(posedge PLL0LOCKDETCLK or posedge pll0_reset_int) begin
        if (pll0_reset_int) begin
            r_state      <= S_IDLE;
            r_timer      <= 16'd0;
            r_stable_cnt <= 16'd0;
            r_lol_count  <= 8'd0;
            r_lol_sticky <= 1'b0;
        end else begin
            // Status registers are independent of the start level.
            r_lol_count <= w_lol_next;
            if (w_loss_event) begin
                r_lol_sticky <= 1'b1;
            end else if (i_clr_status) begin
                r_lol_sticky <= 1'b0;
            end

            if (!i_start) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_WAIT_LOCK;
                        r_timer <= 16'd0;
                    end

                    S_WAIT_LOCK, S_LOST: begin
                        r_timer <= w_timer_inc;
                        if (w_lock_good) begin
                            r_state      <= S_QUALIFY;
                            r_stable_cnt <= 16'd0;
                        end else if (w_timer_expired) begin
                            r_state <= S_TIMEOUT;
                        end
                    end

                    S_QUALIFY: begin
                        r_timer <= w_timer_inc;
                        if (!w_lock_good) begin
                            r_state <= S_WAIT_LOCK;
                        end else if (r_stable_cnt == c_STABLE_LAST) begin
                            r_state <= S_READY;
                        end else begin
                            r_stable_cnt <= r_stable_cnt + 16'd1;
                        end
                    end

                    S_READY: begin
                        if (!w_lock_good) begin
                            r_state <= S_LOST;
                            r_timer <= 16'd0;
                        end
                    end

                    S_TIMEOUT: begin
                        // Held until start drops (handled above).
                        r_state <= S_TIMEOUT;
                    end

                    default: begin
                        // Encodings 6 and 7 recover to IDLE.
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: pure decodes of the state register, so they change with the
    // state at the same edge and clear immediately on asynchronous reset.
    // ------------------------------------------------------------------------
    assign o_state        = r_state;
    assign o_pll_ready    = (r_state == S_READY);
    assign o_timeout_flag = (r_state == S_TIMEOUT);
    assign o_pll0_lock_en = (r_state == S_WAIT_LOCK) || (r_state == S_QUALIFY) ||
                            (r_state == S_READY)     || (r_state == S_LOST);
    assign o_lol_count    = r_lol_count;
    assign o_lol_sticky   = r_lol_sticky;

endmodule
`default_nettype wire

// File: tb/tb_gtp_pll0_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gtp_pll0_lock_monitor
// Description : Directed self-checking bench for gtp_pll0_lock_monitor.
//               One instance uses short parameters for the directed cases,
//               a second uses defaults and is driven by a simple PLL0 lock
//               model that asserts lock 101 enabled cycles after enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gtp_pll0_lock_monitor;

    localparam int c_ST = 4;
    localparam int c_TO = 16;

    logic       clk;
    logic       rst;
    logic       r_start, r_clr, r_lock, r_fb, r_ref;
    logic       w_lock_en, w_ready, w_sticky, w_tf;
    logic [2:0] w_state;
    logic [7:0] w_count;

    logic       d_start;
    logic       d_lock_en, d_ready, d_sticky, d_tf;
    logic [2:0] d_state;
    logic [7:0] d_count;
    logic [7:0] r_pcnt;
    logic       w_d_lock;

    int n_checks = 0;
    int n_fail   = 0;

    gtp_pll0_lock_monitor #(.STABLE_CYCLES(c_ST), .TIMEOUT_CYCLES(c_TO)) dut (
        .PLL0LOCKDETCLK    (clk),
        .pll0_reset_int    (rst),
        .i_start           (r_start),
        .i_clr_status      (r_clr),
        .i_pll0_lock       (r_lock),
        .i_pll0_fbclklost  (r_fb),
        .i_pll0_refclklost (r_ref),
        .o_pll0_lock_en    (w_lock_en),
        .o_pll_ready       (w_ready),
        .o_state           (w_state),
        .o_lol_count       (w_count),
        .o_lol_sticky      (w_sticky),
        .o_timeout_flag    (w_tf)
    );

    gtp_pll0_lock_monitor dut_d (
        .PLL0LOCKDETCLK    (clk),
        .pll0_reset_int    (rst),
        .i_start           (d_start),
        .i_clr_status      (1'b0),
        .i_pll0_lock       (w_d_lock),
        .i_pll0_fbclklost  (1'b0),
        .i_pll0_refclklost (1'b0),
        .o_pll0_lock_en    (d_lock_en),
        .o_pll_ready       (d_ready),
        .o_state           (d_state),
        .o_lol_count       (d_count),
        .o_lol_sticky      (d_sticky),
        .o_timeout_flag    (d_tf)
    );

    // Upstream PLL0 stand-in: counts enabled cycles, locks at 101.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_pcnt <= 8'd0;
        else if (!d_lock_en) r_pcnt <= 8'd0;
        else if (r_pcnt != 8'd101) r_pcnt <= r_pcnt + 8'd1;
    end
    assign w_d_lock = (r_pcnt == 8'd101);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // State plus every decoded output that follows from it.
    task automatic expect_state(input string tag, input int s);
        check({tag, ".state"}, 32'(w_state), 32'(s));
        check({tag, ".ready"}, 32'(w_ready), 32'(s == 3));
        check({tag, ".tf"},    32'(w_tf),    32'(s == 5));
        check({tag, ".lken"},  32'(w_lock_en), 32'(s >= 1 && s <= 4));
    endtask

    // Precondition: lock good now. QUALIFY next edge, READY c_ST edges later.
    task automatic qualify(input string tag);
        tick();
        expect_state({tag, ".q0"}, 2);
        for (int i = 1; i < c_ST; i++) tick();
        expect_state({tag, ".q3"}, 2);
        tick();
        expect_state({tag, ".rdy"}, 3);
    endtask

    // One-cycle loss while READY, then relock to READY.
    task automatic loss_relock(input bit use_fb);
        if (use_fb) r_fb = 1'b1; else r_ref = 1'b1;
        tick();
        r_fb  = 1'b0;
        r_ref = 1'b0;
        check("loss.state", 32'(w_state), 32'd4);
        qualify("relock");
    endtask

    initial begin
        int waited;
        int lock_delay;
        int ready_delay;
        bit seen_tf;

        rst = 1'b1; r_start = 0; r_clr = 0; r_lock = 0; r_fb = 0; r_ref = 0;
        d_start = 0;
        #1;
        expect_state("reset", 0);
        check("reset.count",  32'(w_count),  32'd0);
        check("reset.sticky", 32'(w_sticky), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        expect_state("idle", 0);

        // ---- Acquire: lock rises 5 cycles after start ----
        r_start = 1'b1;
        tick();
        expect_state("acq.wait", 1);
        for (int i = 0; i < 4; i++) tick();
        expect_state("acq.wait4", 1);
        r_lock = 1'b1;
        qualify("acq");

        // ---- Loss via refclklost, relock ----
        loss_relock(1'b0);
        check("loss1.count",  32'(w_count),  32'd1);
        check("loss1.sticky", 32'(w_sticky), 32'd1);

        // ---- start=0 to IDLE, status held ----
        r_start = 1'b0;
        tick();
        expect_state("stop", 0);
        check("stop.count", 32'(w_count), 32'd1);

        // ---- Glitch in QUALIFY ----
        r_start = 1'b1;
        tick();
        expect_state("gl.wait", 1);
        tick();
        expect_state("gl.q", 2);
        tick(); tick();
        r_lock = 1'b0;
        tick();
        expect_state("gl.drop", 1);
        r_lock = 1'b1;
        qualify("gl");

        // ---- clr_status ----
        r_clr = 1'b1;
        tick();
        r_clr = 1'b0;
        check("clr.count",  32'(w_count),  32'd0);
        check("clr.sticky", 32'(w_sticky), 32'd0);

        // ---- clr coincident with loss: one event recorded ----
        loss_relock(1'b1);
        check("pre.count", 32'(w_count), 32'd1);
        r_clr = 1'b1; r_ref = 1'b1;
        tick();
        r_clr = 1'b0; r_ref = 1'b0;
        check("clrloss.count",  32'(w_count),  32'd1);
        check("clrloss.sticky", 32'(w_sticky), 32'd1);
        check("clrloss.state",  32'(w_state),  32'd4);
        qualify("clrloss");

        // ---- 300 losses: saturates at 255 ----
        for (int i = 0; i < 300; i++) begin
            loss_relock(i[0]);
            if (i == 100) check("sat.mid", 32'(w_count), 32'd102);
        end
        check("sat.count", 32'(w_count), 32'd255);
        r_clr = 1'b1;
        tick();
        r_clr = 1'b0;
        check("sat.clr", 32'(w_count), 32'd0);

        // ---- Async reset in READY with lol_count=3 ----
        for (int i = 0; i < 3; i++) loss_relock(1'b0);
        check("ar.pre", 32'(w_count), 32'd3);
        rst = 1'b1;
        #1;
        expect_state("ar", 0);
        check("ar.count",  32'(w_count),  32'd0);
        check("ar.sticky", 32'(w_sticky), 32'd0);
        r_start = 1'b0; r_lock = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // ---- Timeout from WAIT_LOCK ----
        r_start = 1'b1;
        tick();
        expect_state("to.wait", 1);
        for (int i = 0; i < c_TO - 1; i++) tick();
        expect_state("to.wait15", 1);
        tick();
        expect_state("to.hit", 5);
        r_lock = 1'b1;
        tick(); tick();
        expect_state("to.hold", 5);
        r_start = 1'b0;
        tick();
        expect_state("to.exit", 0);

        // ---- Timeout from LOST ----
        r_start = 1'b1;
        tick();
        qualify("lt");
        r_lock = 1'b0;
        tick();
        expect_state("lt.lost", 4);
        for (int i = 0; i < c_TO - 1; i++) tick();
        expect_state("lt.lost15", 4);
        tick();
        expect_state("lt.hit", 5);
        r_start = 1'b0;
        tick();

        // ---- Integration with default parameters ----
        d_start = 1'b1;
        tick();
        check("int.lken", 32'(d_lock_en), 32'd1);
        lock_delay  = -1;
        ready_delay = -1;
        seen_tf     = 1'b0;
        waited      = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            waited++;
            if (d_tf) seen_tf = 1'b1;
            if (lock_delay < 0 && w_d_lock) begin
                lock_delay = waited;
                waited = 0;
            end else if (lock_delay >= 0 && d_ready) begin
                ready_delay = waited;
                break;
            end
        end
        check("int.lock_delay",  32'(lock_delay >= 100 && lock_delay <= 102), 32'd1);
        // Lock seen after edge X is first sampled at X+1, READY after X+1+64.
        check("int.ready_delay", 32'(ready_delay), 32'd65);
        check("int.no_timeout",  32'(seen_tf), 32'd0);
        check("int.state",       32'(d_state), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
